// File: rtl/clk_div_monitor.sv
// Monitors a divided clock in the source clock domain: detects rising edges,
// measures period/high time, and tracks lock, mismatch and stall.
module clk_div_monitor #(
    parameter int EXP_PERIOD = 4,
    parameter int EXP_HIGH   = 2,
    parameter int TOL        = 0,
    parameter int LOCK_CNT   = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_div_num,
    input  logic             en,
    input  logic             err_clr,
    output logic             tick,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high,
    output logic             lock,
    output logic             err,
    output logic             stall
);

    localparam int               TW     = CNT_W + 2;
    localparam logic [CNT_W-1:0] MAX    = '1;
    localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       LOCK_N = 4'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        MEAS,
        LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic             s0_q, s0_d;
    logic             s1_q, s1_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [3:0]       match_q, match_d;
    logic             tick_q, tick_d;
    logic             mv_q, mv_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             lock_q, lock_d;
    logic             err_q, err_d;
    logic             stall_q, stall_d;

    logic             rise;
    logic             sample_ok;
    logic             err_ev;
    logic             stall_ev;
    logic [3:0]       match_inc;

    // Saturating increment: counters stick at MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic inc);
        if (inc && (v != MAX)) begin
            return v + ONE;
        end
        return v;
    endfunction

    function automatic logic within_tol(input logic [CNT_W-1:0] meas,
                                        input int expv);
        logic signed [TW-1:0] m_s;
        logic signed [TW-1:0] e_s;
        logic signed [TW-1:0] d_s;
        m_s = $signed({2'b00, meas});
        e_s = TW'(expv);
        d_s = m_s - e_s;
        if (d_s < 0) begin
            d_s = -d_s;
        end
        return (d_s <= TW'(TOL));
    endfunction

    assign rise      = s0_q & ~s1_q;
    assign sample_ok = within_tol(per_cnt_q, EXP_PERIOD) && within_tol(hi_cnt_q, EXP_HIGH);
    assign match_inc = match_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        s0_d      = clk_div_num;
        s1_d      = s0_q;
        match_d   = match_q;
        tick_d    = 1'b0;
        mv_d      = 1'b0;
        period_d  = period_q;
        high_d    = high_q;
        lock_d    = lock_q;
        err_d     = err_q;
        stall_d   = stall_q;
        err_ev    = 1'b0;
        stall_ev  = 1'b0;

        // The rise sample itself is high, so both counters restart at 1.
        if (rise) begin
            per_cnt_d = ONE;
            hi_cnt_d  = ONE;
        end else begin
            per_cnt_d = sat_inc(per_cnt_q, 1'b1);
            hi_cnt_d  = sat_inc(hi_cnt_q, s0_q);
        end

        case (state_q)
            IDLE: begin
                per_cnt_d = '0;
                hi_cnt_d  = '0;
                match_d   = '0;
                lock_d    = 1'b0;
                if (en) begin
                    state_d = ACQ;
                end
            end
            ACQ: begin
                if (rise) begin
                    tick_d  = 1'b1;
                    match_d = '0;
                    state_d = MEAS;
                end
            end
            MEAS: begin
                if (rise) begin
                    tick_d   = 1'b1;
                    mv_d     = 1'b1;
                    period_d = per_cnt_q;
                    high_d   = hi_cnt_q;
                    if (sample_ok) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_N) begin
                            lock_d  = 1'b1;
                            state_d = LOCKED;
                        end
                    end else begin
                        match_d = '0;
                    end
                end else if (per_cnt_d == MAX) begin
                    stall_ev = 1'b1;
                    lock_d   = 1'b0;
                    state_d  = ACQ;
                end
            end
            LOCKED: begin
                if (rise) begin
                    tick_d   = 1'b1;
                    mv_d     = 1'b1;
                    period_d = per_cnt_q;
                    high_d   = hi_cnt_q;
                    if (!sample_ok) begin
                        err_ev  = 1'b1;
                        lock_d  = 1'b0;
                        match_d = '0;
                        state_d = MEAS;
                    end
                end else if (per_cnt_d == MAX) begin
                    stall_ev = 1'b1;
                    lock_d   = 1'b0;
                    state_d  = ACQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Disable discards any partial measurement, including one completing now.
        if (!en) begin
            state_d   = IDLE;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
            match_d   = '0;
            tick_d    = 1'b0;
            mv_d      = 1'b0;
            period_d  = period_q;
            high_d    = high_q;
            lock_d    = 1'b0;
            err_ev    = 1'b0;
            stall_ev  = 1'b0;
        end

        if (err_clr) begin
            err_d   = 1'b0;
            stall_d = 1'b0;
        end
        if (err_ev) begin
            err_d = 1'b1;
        end
        if (stall_ev) begin
            err_d   = 1'b1;
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            match_q   <= '0;
            tick_q    <= 1'b0;
            mv_q      <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            lock_q    <= 1'b0;
            err_q     <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            match_q   <= match_d;
            tick_q    <= tick_d;
            mv_q      <= mv_d;
            period_q  <= period_d;
            high_q    <= high_d;
            lock_q    <= lock_d;
            err_q     <= err_d;
            stall_q   <= stall_d;
        end
    end

    assign tick       = tick_q;
    assign meas_valid = mv_q;
    assign period     = period_q;
    assign high       = high_q;
    assign lock       = lock_q;
    assign err        = err_q;
    assign stall      = stall_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: the bench plays the divider waveform
// sample by sample and compares outputs against hand-computed values.
module tb_clk_div_monitor;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clk_div_num = 1'b0;
    logic             en = 1'b0;
    logic             err_clr = 1'b0;
    logic             tick;
    logic             meas_valid;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic             lock;
    logic             err;
    logic             stall;

    int n_checks = 0;
    int n_errors = 0;
    int mv_sum;
    int tick_sum;
    logic             snap_tick, snap_mv, snap_lock, snap_err, snap_stall;
    logic [CNT_W-1:0] snap_period, snap_high;

    clk_div_monitor #(
        .EXP_PERIOD(4),
        .EXP_HIGH  (2),
        .TOL       (0),
        .LOCK_CNT  (3),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_div_num(clk_div_num),
        .en         (en),
        .err_clr    (err_clr),
        .tick       (tick),
        .meas_valid (meas_valid),
        .period     (period),
        .high       (high),
        .lock       (lock),
        .err        (err),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One posedge with the given divided-clock sample; outputs read 1 time unit later.
    task automatic step(input logic v);
        clk_div_num = v;
        @(posedge clk);
        #1;
        mv_sum   += int'(meas_valid);
        tick_sum += int'(tick);
    endtask

    // One divided cycle; the snapshot is taken where this cycle's rise is reported.
    task automatic run_cycle(input int hi, input int per, input bit clr_at1);
        mv_sum   = 0;
        tick_sum = 0;
        for (int i = 0; i < per; i++) begin
            err_clr = (clr_at1 && i == 1);
            step(i < hi);
            if (i == 1) begin
                snap_tick   = tick;
                snap_mv     = meas_valid;
                snap_period = period;
                snap_high   = high;
                snap_lock   = lock;
                snap_err    = err;
                snap_stall  = stall;
            end
        end
        err_clr = 1'b0;
    endtask

    task automatic chk_cycle(input string tag, input int et, input int emv, input int ep,
                             input int eh, input int el, input int ee, input int es);
        chk({tag, "_tick_cnt"}, tick_sum, et);
        chk({tag, "_tick"}, 32'(snap_tick), et);
        chk({tag, "_mv_cnt"}, mv_sum, emv);
        chk({tag, "_period"}, 32'(snap_period), ep);
        chk({tag, "_high"}, 32'(snap_high), eh);
        chk({tag, "_lock"}, 32'(snap_lock), el);
        chk({tag, "_err"}, 32'(snap_err), ee);
        chk({tag, "_stall"}, 32'(snap_stall), es);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tick"}, 32'(tick), 0);
        chk({tag, "_mv"}, 32'(meas_valid), 0);
        chk({tag, "_period"}, 32'(period), 0);
        chk({tag, "_high"}, 32'(high), 0);
        chk({tag, "_lock"}, 32'(lock), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_stall"}, 32'(stall), 0);
    endtask

    // From IDLE with en=1: ACQ rise, then lock on the third meas_valid.
    task automatic run_lock_seq(input string tag);
        step(1'b0);
        step(1'b0);
        run_cycle(2, 4, 1'b0); chk_cycle({tag, "_acq"}, 1, 0, 0, 0, 0, 0, 0);
        run_cycle(2, 4, 1'b0); chk_cycle({tag, "_m1"},  1, 1, 4, 2, 0, 0, 0);
        run_cycle(2, 4, 1'b0); chk_cycle({tag, "_m2"},  1, 1, 4, 2, 0, 0, 0);
        run_cycle(2, 4, 1'b0); chk_cycle({tag, "_m3"},  1, 1, 4, 2, 1, 0, 0);
        run_cycle(2, 4, 1'b0); chk_cycle({tag, "_m4"},  1, 1, 4, 2, 1, 0, 0);
    endtask

    initial begin
        en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        run_lock_seq("basic");

        // Duty mismatch after lock, then relock with err still set
        run_cycle(3, 4, 1'b0); chk_cycle("duty_bad", 1, 1, 4, 2, 1, 0, 0);
        run_cycle(2, 4, 1'b0); chk_cycle("duty_det", 1, 1, 4, 3, 0, 1, 0);
        run_cycle(2, 4, 1'b0); chk_cycle("duty_r1",  1, 1, 4, 2, 0, 1, 0);
        run_cycle(2, 4, 1'b0); chk_cycle("duty_r2",  1, 1, 4, 2, 0, 1, 0);
        run_cycle(2, 4, 1'b0); chk_cycle("duty_r3",  1, 1, 4, 2, 1, 1, 0);

        // Stall: last rise sample was the first posedge of the previous cycle
        mv_sum   = 0;
        tick_sum = 0;
        for (int i = 0; i < 11; i++) step(1'b0);
        chk("stall_pre_mv", mv_sum, 0);
        chk("stall_pre_tick", tick_sum, 0);
        chk("stall_pre_stall", 32'(stall), 0);
        chk("stall_pre_lock", 32'(lock), 1);
        step(1'b0);
        chk("stall_stall", 32'(stall), 1);
        chk("stall_err", 32'(err), 1);
        chk("stall_lock", 32'(lock), 0);
        run_cycle(2, 4, 1'b0); chk_cycle("stall_acq", 1, 0, 4, 2, 0, 1, 1);
        run_cycle(2, 4, 1'b0); chk_cycle("stall_m1",  1, 1, 4, 2, 0, 1, 1);
        run_cycle(2, 4, 1'b0); chk_cycle("stall_m2",  1, 1, 4, 2, 0, 1, 1);
        run_cycle(2, 4, 1'b0); chk_cycle("stall_m3",  1, 1, 4, 2, 1, 1, 1);

        // err_clr racing a mismatch, then a lone err_clr
        run_cycle(3, 4, 1'b0); chk_cycle("race_bad", 1, 1, 4, 2, 1, 1, 1);
        run_cycle(2, 4, 1'b1); chk_cycle("race_hit", 1, 1, 4, 3, 0, 1, 0);
        run_cycle(2, 4, 1'b1); chk_cycle("race_clr", 1, 1, 4, 2, 0, 0, 0);

        // Enable drop for three cycles in the middle of a period
        run_cycle(2, 4, 1'b0); chk_cycle("en_m2", 1, 1, 4, 2, 0, 0, 0);
        step(1'b1);
        step(1'b1);
        chk("en_lock_mv", 32'(meas_valid), 1);
        chk("en_lock_lock", 32'(lock), 1);
        en       = 1'b0;
        mv_sum   = 0;
        tick_sum = 0;
        step(1'b0);
        chk("en_off_lock", 32'(lock), 0);
        step(1'b0);
        step(1'b1);
        en = 1'b1;
        step(1'b1);
        step(1'b0);
        step(1'b0);
        chk("en_off_mv", mv_sum, 0);
        chk("en_off_tick", tick_sum, 0);
        chk("en_off_period", 32'(period), 4);
        run_cycle(2, 4, 1'b0); chk_cycle("en_acq", 1, 0, 4, 2, 0, 0, 0);
        run_cycle(2, 4, 1'b0); chk_cycle("en_m1",  1, 1, 4, 2, 0, 0, 0);
        run_cycle(2, 4, 1'b0); chk_cycle("en_m2b", 1, 1, 4, 2, 0, 0, 0);
        run_cycle(2, 4, 1'b0); chk_cycle("en_m3",  1, 1, 4, 2, 1, 0, 0);

        // Asynchronous reset pulse between clock edges
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        chk_zero("rst_hold");
        rst_n = 1'b1;

        run_lock_seq("relock");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
